// File: rtl/ikbd_uart_pkg.sv
// Shared constants and FSM state types for the IKBD serial endpoint.
package ikbd_uart_pkg;

    localparam int unsigned OVS        = 16;  // oversample ticks per bit
    localparam int unsigned FRAME_BITS = 10;  // start + 8 data + stop
    localparam int unsigned DATA_W     = 8;

    typedef enum logic [0:0] {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/ikbd_uart_txfifo.sv
// Transmit byte FIFO with wrap-bit pointers; full/empty are registered flags.
module ikbd_uart_txfifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data_c,
    output logic             full,
    output logic             empty,
    output logic             empty_nxt_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             push_ok_c;
    logic             pop_ok_c;

    // Full is the registered flag, so a push while full is dropped even on a pop cycle
    assign push_ok_c   = push && !full;
    assign pop_ok_c    = pop && !empty;
    assign wr_ptr_nxt  = wr_ptr + PW'(push_ok_c);
    assign rd_ptr_nxt  = rd_ptr + PW'(pop_ok_c);
    assign empty_nxt_c = (wr_ptr_nxt == rd_ptr_nxt);
    assign pop_data_c  = mem[rd_ptr[AW-1:0]];

    // Pointer and flag registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= ((wr_ptr_nxt - rd_ptr_nxt) == PW'(DEPTH));
            empty  <= empty_nxt_c;
        end
    end

    // Storage write
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/ikbd_uart.sv
// Keyboard-side 8N1 serial endpoint of the IKBD link (16x oversampled).
// Optional RX glitch filter: define IKBD_UART_RX_FILTER_EN.
module ikbd_uart
    import ikbd_uart_pkg::*;
#(
    parameter int unsigned TICK_DIV = 64,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_strobe,
    output logic              tx_full,
    output logic              tx_busy,
    output logic              ikbd_tx,
    input  logic              ikbd_rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_frame_err
);

    localparam int unsigned TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned OW  = $clog2(OVS);
    localparam int unsigned BW  = $clog2(FRAME_BITS);
    localparam int unsigned DBW = $clog2(DATA_W);

    logic [TW-1:0] tick_cnt;
    logic          tick_c;

    assign tick_c = (tick_cnt == TW'(TICK_DIV - 1));

    // Free-running oversample tick generator
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    tick_cnt <= '0;
        else if (tick_c) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + TW'(1);
    end

    logic              fifo_pop_c;
    logic              fifo_empty;
    logic              fifo_empty_nxt_c;
    logic [DATA_W-1:0] fifo_rd_data_c;

    ikbd_uart_txfifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (DATA_W)
    ) u_txfifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (tx_strobe),
        .push_data   (tx_data),
        .pop         (fifo_pop_c),
        .pop_data_c  (fifo_rd_data_c),
        .full        (tx_full),
        .empty       (fifo_empty),
        .empty_nxt_c (fifo_empty_nxt_c)
    );

    tx_state_t             tx_state, tx_state_nxt;
    logic [FRAME_BITS-1:0] tx_shift, tx_shift_nxt;
    logic [BW-1:0]         tx_bit, tx_bit_nxt;
    logic [OW-1:0]         tx_ovs, tx_ovs_nxt;
    logic                  ikbd_tx_nxt;
    logic                  tx_busy_nxt;
    logic                  tx_load_c;

    // TX next state: load on tick when data waits, reload back-to-back after the stop bit
    always_comb begin
        tx_state_nxt = tx_state;
        tx_shift_nxt = tx_shift;
        tx_bit_nxt   = tx_bit;
        tx_ovs_nxt   = tx_ovs;
        ikbd_tx_nxt  = ikbd_tx;
        tx_load_c    = 1'b0;
        if (tick_c) begin
            case (tx_state)
                TX_IDLE: tx_load_c = !fifo_empty;
                TX_SHIFT: begin
                    if (tx_ovs == OW'(OVS - 1)) begin
                        tx_ovs_nxt = '0;
                        if (tx_bit == BW'(FRAME_BITS - 1)) begin
                            tx_load_c = !fifo_empty;
                            if (fifo_empty) begin
                                tx_state_nxt = TX_IDLE;
                                ikbd_tx_nxt  = 1'b1;
                            end
                        end else begin
                            tx_shift_nxt = {1'b1, tx_shift[FRAME_BITS-1:1]};
                            tx_bit_nxt   = tx_bit + BW'(1);
                            ikbd_tx_nxt  = tx_shift[1];
                        end
                    end else begin
                        tx_ovs_nxt = tx_ovs + OW'(1);
                    end
                end
                default: tx_state_nxt = TX_IDLE;
            endcase
            if (tx_load_c) begin
                tx_state_nxt = TX_SHIFT;
                tx_shift_nxt = {1'b1, fifo_rd_data_c, 1'b0};
                tx_bit_nxt   = '0;
                tx_ovs_nxt   = '0;
                ikbd_tx_nxt  = 1'b0;
            end
        end
    end

    assign fifo_pop_c  = tx_load_c;
    assign tx_busy_nxt = (tx_state_nxt == TX_SHIFT) || !fifo_empty_nxt_c;

    // TX state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_shift <= '1;
            tx_bit   <= '0;
            tx_ovs   <= '0;
            ikbd_tx  <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_shift <= tx_shift_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_ovs   <= tx_ovs_nxt;
            ikbd_tx  <= ikbd_tx_nxt;
            tx_busy  <= tx_busy_nxt;
        end
    end

    logic [1:0] rx_sync;
    logic       rx_line;

    // Two-flop synchronizer for the asynchronous line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_sync <= 2'b11;
        else          rx_sync <= {rx_sync[0], ikbd_rx};
    end

`ifdef IKBD_UART_RX_FILTER_EN
    localparam int unsigned FILT_N = 4;

    logic [FILT_N-1:0] rx_filt;
    logic [FILT_N-1:0] rx_filt_nxt_c;

    assign rx_filt_nxt_c = {rx_filt[FILT_N-2:0], rx_sync[1]};

    // Majority-free glitch filter: line only moves when all tick samples agree
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_filt <= '1;
            rx_line <= 1'b1;
        end else if (tick_c) begin
            rx_filt <= rx_filt_nxt_c;
            if (&rx_filt_nxt_c)       rx_line <= 1'b1;
            else if (~|rx_filt_nxt_c) rx_line <= 1'b0;
        end
    end
`else
    assign rx_line = rx_sync[1];
`endif

    rx_state_t          rx_state, rx_state_nxt;
    logic [OW-1:0]      rx_ovs, rx_ovs_nxt;
    logic [DBW-1:0]     rx_bit, rx_bit_nxt;
    logic [DATA_W-1:0]  rx_shift, rx_shift_nxt;
    logic [DATA_W-1:0]  rx_data_nxt;
    logic               rx_valid_nxt;
    logic               rx_frame_err_nxt;

    // RX next state: mid-bit sampling from start detection, error waits for idle line
    always_comb begin
        rx_state_nxt     = rx_state;
        rx_ovs_nxt       = rx_ovs;
        rx_bit_nxt       = rx_bit;
        rx_shift_nxt     = rx_shift;
        rx_data_nxt      = rx_data;
        rx_valid_nxt     = 1'b0;
        rx_frame_err_nxt = 1'b0;
        if (tick_c) begin
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_line) begin
                        rx_state_nxt = RX_START;
                        rx_ovs_nxt   = '0;
                    end
                end
                RX_START: begin
                    if (rx_ovs == OW'(OVS / 2 - 1)) begin
                        rx_ovs_nxt   = '0;
                        rx_bit_nxt   = '0;
                        rx_state_nxt = rx_line ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_ovs_nxt = rx_ovs + OW'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_ovs == OW'(OVS - 1)) begin
                        rx_ovs_nxt   = '0;
                        rx_shift_nxt = {rx_line, rx_shift[DATA_W-1:1]};
                        if (rx_bit == DBW'(DATA_W - 1)) rx_state_nxt = RX_STOP;
                        else                            rx_bit_nxt   = rx_bit + DBW'(1);
                    end else begin
                        rx_ovs_nxt = rx_ovs + OW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_ovs == OW'(OVS - 1)) begin
                        rx_ovs_nxt = '0;
                        if (rx_line) begin
                            rx_data_nxt  = rx_shift;
                            rx_valid_nxt = 1'b1;
                            rx_state_nxt = RX_IDLE;
                        end else begin
                            rx_frame_err_nxt = 1'b1;
                            rx_state_nxt     = RX_WAIT_IDLE;
                        end
                    end else begin
                        rx_ovs_nxt = rx_ovs + OW'(1);
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_line) rx_state_nxt = RX_IDLE;
                end
                default: rx_state_nxt = RX_IDLE;
            endcase
        end
    end

    // RX state and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state     <= RX_IDLE;
            rx_ovs       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_state     <= rx_state_nxt;
            rx_ovs       <= rx_ovs_nxt;
            rx_bit       <= rx_bit_nxt;
            rx_shift     <= rx_shift_nxt;
            rx_data      <= rx_data_nxt;
            rx_valid     <= rx_valid_nxt;
            rx_frame_err <= rx_frame_err_nxt;
        end
    end

endmodule

// File: tb/tb_ikbd_uart.sv
// Scoreboard bench for ikbd_uart: TX line decoder and RX pulse monitor check queued expectations.
module tb_ikbd_uart;

    localparam int unsigned TICK_DIV   = 64;
    localparam int unsigned TX_DEPTH   = 4;
    localparam int          BIT_CLKS   = 1024;
    localparam int          FRAME_CLKS = 10240;

    logic       clk;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_strobe;
    logic       tx_full;
    logic       tx_busy;
    logic       ikbd_tx;
    logic       ikbd_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;

    ikbd_uart #(
        .TICK_DIV (TICK_DIV),
        .TX_DEPTH (TX_DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tx_data      (tx_data),
        .tx_strobe    (tx_strobe),
        .tx_full      (tx_full),
        .tx_busy      (tx_busy),
        .ikbd_tx      (ikbd_tx),
        .ikbd_rx      (ikbd_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Expected RX events: err=0 -> rx_valid with data, err=1 -> rx_frame_err with data unchanged
    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rx_exp_t;

    rx_exp_t    rx_q[$];
    logic [7:0] tx_q[$];
    int         tx_starts[$];
    int         rx_pulses = 0;
    bit         tx_rst_seen = 0;

    always @(negedge reset_n) tx_rst_seen = 1;

    // RX monitor: every pulse consumes one expectation
    always @(negedge clk) begin
        if (rx_valid || rx_frame_err) begin
            rx_exp_t e;
            rx_pulses++;
            if (rx_q.size() == 0) begin
                total++;
                $display("FAIL rx_unexpected_pulse: got valid=%0b err=%0b data=%0h required none",
                         rx_valid, rx_frame_err, rx_data);
            end else begin
                e = rx_q.pop_front();
                check("rx_kind", {30'd0, rx_valid, rx_frame_err}, e.err ? 32'd1 : 32'd2);
                check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
            end
        end
    end

    // TX monitor: decode 8N1 frames off ikbd_tx at mid-bit, log start cycles
    initial begin : tx_mon
        logic       prev;
        logic [9:0] f;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !ikbd_tx && reset_n) begin
                tx_rst_seen = 0;
                tx_starts.push_back(cyc);
                repeat (BIT_CLKS / 2) @(negedge clk);
                for (int i = 0; i < 10; i++) begin
                    f[i] = ikbd_tx;
                    if (i < 9) repeat (BIT_CLKS) @(negedge clk);
                end
                if (!tx_rst_seen) begin
                    if (tx_q.size() == 0) begin
                        total++;
                        $display("FAIL tx_unexpected_frame: got %b required none", f);
                    end else begin
                        e = tx_q.pop_front();
                        check("tx_frame", {22'd0, f}, {22'd0, 1'b1, e, 1'b0});
                    end
                end
            end
            prev = ikbd_tx;
        end
    end

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        tx_data   = d;
        tx_strobe = 1'b1;
        @(negedge clk);
        tx_strobe = 1'b0;
    endtask

    // Drive one frame; line is left at the stop-bit level
    task automatic rx_frame(input logic [7:0] d, input int bit_clks, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            ikbd_rx = f[i];
            repeat (bit_clks) @(negedge clk);
        end
    endtask

    task automatic tx_seq();
        int         k;
        int         m;
        logic [7:0] b [5];
        b = '{8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        // Single frame: latency, bit pattern, busy duration
        tx_q.push_back(8'hA5);
        push_byte(8'hA5);
        check("tx_busy_after_push", {31'd0, tx_busy}, 32'd1);
        k = 1;
        while (ikbd_tx && k <= 70) begin
            @(negedge clk);
            k++;
        end
        if (k > 65) begin
            total++;
            $display("FAIL tx_start_latency: got %0d clocks required 1..65", k);
        end else begin
            check("tx_start_line_low", {31'd0, ikbd_tx}, 32'd0);
        end
        m = 0;
        while (tx_busy && m < FRAME_CLKS + 200) begin
            @(negedge clk);
            m++;
        end
        check("tx_busy_fall_clocks", m, FRAME_CLKS);

        // Back-to-back: one byte in flight, then five pushes on consecutive clocks
        repeat (20) @(negedge clk);
        tx_starts.delete();
        tx_q.push_back(8'h11);
        push_byte(8'h11);
        k = 0;
        while (ikbd_tx && k < 100) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 5; i++) begin
            tx_data   = b[i];
            tx_strobe = 1'b1;
            if (i < 4) tx_q.push_back(b[i]);
            @(negedge clk);
            if (i == 2) check("tx_full_after_3", {31'd0, tx_full}, 32'd0);
            if (i == 3) check("tx_full_after_4", {31'd0, tx_full}, 32'd1);
        end
        tx_strobe = 1'b0;
        @(negedge clk);
        check("tx_full_hold", {31'd0, tx_full}, 32'd1);
        m = 0;
        while (tx_busy && m < 6 * FRAME_CLKS) begin
            @(negedge clk);
            m++;
        end
        check("tx_b2b_drained", {31'd0, tx_busy}, 32'd0);
        check("tx_b2b_frames", tx_starts.size(), 32'd5);
        for (int i = 1; i < tx_starts.size(); i++) begin
            check("tx_b2b_gap", tx_starts[i] - tx_starts[i-1], FRAME_CLKS);
        end
    endtask

    task automatic rx_seq();
        int p;
        int rates [3];
        rates = '{1024, 994, 1054};

        // Good frames at nominal and +/-3 % rates
        for (int i = 0; i < 3; i++) begin
            rx_q.push_back('{err: 1'b0, data: 8'h3C});
            rx_frame(8'h3C, rates[i], 1'b1);
            ikbd_rx = 1'b1;
            repeat (BIT_CLKS) @(negedge clk);
            check("rx_data_3c", {24'd0, rx_data}, 32'h3C);
        end

        // Short low glitch must not produce any pulse
        p = rx_pulses;
        ikbd_rx = 1'b0;
        repeat (100) @(negedge clk);
        ikbd_rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("rx_glitch_no_pulse", rx_pulses, p);

        // Framing error followed by a 20-bit break
        rx_q.push_back('{err: 1'b1, data: 8'h3C});
        p = rx_pulses;
        rx_frame(8'h55, BIT_CLKS, 1'b0);
        repeat (20 * BIT_CLKS) @(negedge clk);
        ikbd_rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("rx_err_single_pulse", rx_pulses, p + 1);
        check("rx_data_kept", {24'd0, rx_data}, 32'h3C);

        // Recovery frame
        rx_q.push_back('{err: 1'b0, data: 8'h81});
        rx_frame(8'h81, BIT_CLKS, 1'b1);
        ikbd_rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("rx_data_81", {24'd0, rx_data}, 32'h81);
    endtask

    task automatic reset_test();
        int k;
        int p;
        push_byte(8'h00);
        k = 0;
        while (ikbd_tx && k < 100) begin
            @(negedge clk);
            k++;
        end
        p = rx_pulses;
        ikbd_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        ikbd_rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        ikbd_rx = 1'b0;
        repeat (BIT_CLKS / 2) @(negedge clk);
        check("tx_mid_frame_low", {31'd0, ikbd_tx}, 32'd0);
        #2 reset_n = 1'b0;
        #1 check("tx_async_reset", {31'd0, ikbd_tx}, 32'd1);
        ikbd_rx = 1'b1;
        repeat (200) @(negedge clk);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        reset_n = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check("post_rst_ikbd_tx", {31'd0, ikbd_tx}, 32'd1);
        check("post_rst_tx_full", {31'd0, tx_full}, 32'd0);
        check("post_rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("post_rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("post_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("post_rst_rx_err", {31'd0, rx_frame_err}, 32'd0);
        check("rst_no_pulses", rx_pulses, p);
    endtask

    // Main sequence: reset values, TX and RX in parallel, then reset mid-traffic
    initial begin
        reset_n   = 1'b0;
        tx_data   = 8'h00;
        tx_strobe = 1'b0;
        ikbd_rx   = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ikbd_tx", {31'd0, ikbd_tx}, 32'd1);
        check("rst_tx_full", {31'd0, tx_full}, 32'd0);
        check("rst_tx_busy0", {31'd0, tx_busy}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_err", {31'd0, rx_frame_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        fork
            tx_seq();
            rx_seq();
        join
        reset_test();
        check("tx_queue_drained", tx_q.size(), 32'd0);
        check("rx_queue_drained", rx_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ikbd_uart.md
# ikbd_uart

Keyboard-side serial endpoint of the ST IKBD link, the far end of the CPU-side ACIA. Serializes bytes from the io controller onto the 8N1 line into the ACIA receiver, and deserializes bytes the ACIA transmits, both at 7812.5 bit/s with a 16x oversampled bit clock. It replaces the SPI byte-FIFO shortcut where a real serial IKBD path is required, for example for external keyboard hardware or timing-exact emulation.

## Interface
- TICK_DIV, 64: system clocks per oversample tick. At 8 MHz: 64 × 16 = 1024 clocks/bit = 7812.5 bit/s.
- TX_DEPTH, 4: transmit FIFO depth; power of two, ≥ 2.
- clk  in  1  system clock, 8 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte from io controller.
- tx_strobe  in  1  one-clock push of tx_data.
- tx_full  out  1  FIFO full; a push while high is dropped.
- tx_busy  out  1  frame on the line, or FIFO not empty.
- ikbd_tx  out  1  serial line to the ACIA RX pin; idle high.
- ikbd_rx  in  1  serial line from the ACIA TX pin; asynchronous.
- rx_data  out  8  last received byte; holds until the next good frame.
- rx_valid  out  1  one-clock pulse when a good frame is received.
- rx_frame_err  out  1  one-clock pulse when the stop bit is sampled low.

## Operation
- Tick generator: free-running counter 0..TICK_DIV-1. The tick is the clock where the count equals TICK_DIV-1. The counter is not restarted by line events.
- TX FIFO:
  - Push on tx_strobe when not full.
  - Full is evaluated before any same-cycle pop, so a push while full is dropped even if a pop occurs that clock.
  - Pointers are log2(TX_DEPTH)+1 bits and wrap naturally.
- TX FSM: TX_IDLE → TX_SHIFT.
  - In TX_IDLE, on a tick with the FIFO non-empty: pop, load shift register {stop=1, data, start=0}, enter TX_SHIFT.
  - In TX_SHIFT, each bit is held 16 ticks, LSB first after the start bit.
  - After the 16th tick of the stop bit: if the FIFO is non-empty, load the next byte on that same tick (back-to-back, no idle gap); otherwise return to TX_IDLE.
  - ikbd_tx is a register.
- RX input: 2-FF synchronizer on ikbd_rx, then the filter (see Configuration), giving rx_line.
- RX FSM: RX_IDLE → RX_START → RX_DATA → RX_STOP, with RX_WAIT_IDLE after an error.
  - RX_IDLE: on a tick with rx_line=0, go to RX_START and count 8 ticks.
  - RX_START: at mid-bit, if rx_line=1 it was a false start; return to RX_IDLE with no pulse. Otherwise go to RX_DATA.
  - RX_DATA: sample every 16 ticks, 8 times; shift right, new bit into MSB.
  - RX_STOP: sample 16 ticks later.
    - If 1: update rx_data, pulse rx_valid, go to RX_IDLE.
    - If 0: pulse rx_frame_err, leave rx_data unchanged, go to RX_WAIT_IDLE.
  - RX_WAIT_IDLE: return to RX_IDLE on the first tick with rx_line=1. This covers break conditions.
- TX and RX are fully independent. Simultaneous activity on both has no interaction.

## Timing
- Reset values: ikbd_tx=1, tx_full=0, tx_busy=0, rx_data=8'h00, rx_valid=0, rx_frame_err=0. Both FSMs idle, FIFO empty, tick counter 0, filter and synchronizer all 1.
- Reset asserted mid-frame: ikbd_tx goes high immediately (asynchronous). Any partial RX byte is discarded with no pulse.
- TX latency: from the tx_strobe clock to the ikbd_tx falling edge, between 1 and TICK_DIV+1 clocks when idle.
- TX frame: exactly 160 ticks = 10240 clocks at the defaults.
- tx_full: asserts the clock after the push that fills the FIFO, and clears the clock after the pop.
- tx_busy: asserts the clock after a push, and drops the clock after the final stop bit ends with the FIFO empty.
- RX pulses: rx_valid and rx_frame_err are registered and high for exactly one clock, on the clock after the stop-sample tick.
- RX latency: from the midpoint of the stop bit to the pulse is at most 2 synchronizer clocks + filter delay + 1 clock.
- RX rate tolerance: must accept ±3 % bit-rate error.

## Configuration
- IKBD_UART_RX_FILTER_EN defined:
  - A 4-bit shift register samples the synchronized input on each tick.
  - rx_line changes only when all 4 samples agree; glitches shorter than 4 ticks are rejected.
  - This adds 3–4 ticks of RX latency.
- Not defined: rx_line is the synchronizer output directly.
- TX behaviour is identical either way.

## Structure
- Package ikbd_uart_pkg holds:
  - OVS = 16 and FRAME_BITS = 10.
  - tx_state_t enum {TX_IDLE, TX_SHIFT}.
  - rx_state_t enum {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE}.
- One sub-module, ikbd_uart_txfifo: synchronous FIFO, parameter DEPTH, with push/pop/full/empty ports.
- The tick generator, both FSMs and the filter stay in the top module.

## Test plan
- Push 8'hA5: ikbd_tx goes low within 65 clocks; mid-bit samples every 1024 clocks read 0,1,0,1,0,0,1,0,1,1; tx_busy falls 10240 clocks after the start edge.
- Push 5 bytes back-to-back at TX_DEPTH=4: tx_full is asserted on the 4th push (one byte already popped) or stays low per occupancy; a push while full is dropped; the emitted frames are contiguous with no idle high gap between stop and start bits.
- Drive 8'h3C on ikbd_rx at 1024 clocks/bit: exactly one rx_valid pulse, rx_data=8'h3C; repeat at 994 and 1054 clocks/bit and get the same result.
- Drive a frame with stop bit 0, then hold the line low for 20 bit times: one rx_frame_err pulse, no rx_valid, rx_data unchanged; after the line returns high, the next 8'h81 frame is received correctly.
- With IKBD_UART_RX_FILTER_EN defined, a 100-clock low glitch produces no pulse; without it, the same glitch is rejected as a false start at mid-start-bit, also with no pulse.
- Assert reset_n low mid-TX and mid-RX: ikbd_tx is 1 within the same clock, no pulses occur, FIFO is empty, and after release the outputs equal the reset values.
